// File: rtl/eeg_pea_out_arb_if.sv
// Bus bundle between the PE-array output streams, layer config and the ORAM write port.
// Suffixes are seen from the arbiter: _i flows into it, _o flows out of it.
interface eeg_pea_out_arb_if #(
  parameter int PE_NUM      = 16,
  parameter int DATA_OUT_DW = 8,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_ADD_AW = 10
);
  logic [ORAM_ADD_AW-1:0]        cfg_out_bas_i;
  logic [PE_NUM-1:0]             cfg_pe_msk_i;
  logic [PE_NUM-1:0]             pe_out_vld_i;
  logic [PE_NUM-1:0]             pe_out_lst_i;
  logic [PE_NUM*DATA_OUT_DW-1:0] pe_out_dat_i;
  logic [PE_NUM*OMUX_ADD_AW-1:0] pe_out_add_i;
  logic [PE_NUM-1:0]             pe_out_rdy_o;
  logic                          oram_wen_o;
  logic                          oram_rdy_i;
  logic [ORAM_ADD_AW-1:0]        oram_add_o;
  logic [DATA_OUT_DW-1:0]        oram_dat_o;
  logic                          done_o;
  logic                          is_idle_o;

  modport slave (
    input  cfg_out_bas_i, cfg_pe_msk_i, pe_out_vld_i, pe_out_lst_i,
           pe_out_dat_i, pe_out_add_i, oram_rdy_i,
    output pe_out_rdy_o, oram_wen_o, oram_add_o, oram_dat_o, done_o, is_idle_o
  );

  modport master (
    output cfg_out_bas_i, cfg_pe_msk_i, pe_out_vld_i, pe_out_lst_i,
           pe_out_dat_i, pe_out_add_i, oram_rdy_i,
    input  pe_out_rdy_o, oram_wen_o, oram_add_o, oram_dat_o, done_o, is_idle_o
  );
endinterface

// File: rtl/eeg_pea_out_arb.sv
// Round-robin collector: merges the per-PE output streams into one registered ORAM write
// stream, forms the global ORAM address and pulses done once every enabled PE sent its last beat.
module eeg_pea_out_arb #(
  parameter int PE_NUM      = 16,
  parameter int DATA_OUT_DW = 8,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_ADD_AW = 10
) (
  input logic              clk,
  input logic              rst,
  eeg_pea_out_arb_if.slave bus
);
  localparam int PE_IDX_AW = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;

  logic [PE_NUM-1:0]      req;
  logic [PE_IDX_AW-1:0]   cand;
  logic [PE_IDX_AW-1:0]   gnt;
  logic                   gnt_vld;
  logic                   load_ok;
  logic                   xfer;
  logic                   oram_hs;
  logic [DATA_OUT_DW-1:0] sel_dat;
  logic [OMUX_ADD_AW-1:0] sel_add;
  logic                   sel_lst;
  logic                   done_cond;

  logic                   wen_q;
  logic [ORAM_ADD_AW-1:0] add_q, add_d;
  logic [DATA_OUT_DW-1:0] dat_q;
  logic                   lst_q;
  logic [PE_IDX_AW-1:0]   gnt_q;
  logic [PE_IDX_AW-1:0]   ptr_q, ptr_d;
  logic [PE_NUM-1:0]      flag_q, flag_d;
  logic                   done_q;

  assign req = bus.pe_out_vld_i & bus.cfg_pe_msk_i;

  // NOTE: every signal written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    // Walk from the farthest candidate back to ptr so the one closest to ptr is written last.
    for (int k = PE_NUM - 1; k >= 0; k--) begin
      cand = PE_IDX_AW'((int'(ptr_q) + k) % PE_NUM);
      if (req[cand]) begin
        gnt     = cand;
        gnt_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dat = '0;
    sel_add = '0;
    sel_lst = 1'b0;
    for (int i = 0; i < PE_NUM; i++) begin
      if (gnt == PE_IDX_AW'(i)) begin
        sel_dat = bus.pe_out_dat_i[i*DATA_OUT_DW +: DATA_OUT_DW];
        sel_add = bus.pe_out_add_i[i*OMUX_ADD_AW +: OMUX_ADD_AW];
        sel_lst = bus.pe_out_lst_i[i];
      end
    end
  end

  assign load_ok = ~wen_q | bus.oram_rdy_i;
  assign xfer    = gnt_vld & load_ok & ~rst;
  assign oram_hs = wen_q & bus.oram_rdy_i;

  // Global address wraps silently at the ORAM size.
  assign add_d = bus.cfg_out_bas_i
               + ORAM_ADD_AW'(int'(sel_add) * PE_NUM)
               + ORAM_ADD_AW'(gnt);
  assign ptr_d = (int'(gnt) == PE_NUM - 1) ? '0 : gnt + 1'b1;

  always_comb begin
    flag_d = flag_q;
    if (oram_hs && lst_q) flag_d[gnt_q] = 1'b1;
  end

  // Includes the handshake in flight so done follows the final last-beat write by one cycle.
  assign done_cond = (&(flag_d | ~bus.cfg_pe_msk_i)) & (|bus.cfg_pe_msk_i);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q  <= 1'b0;
      add_q  <= '0;
      dat_q  <= '0;
      lst_q  <= 1'b0;
      gnt_q  <= '0;
      ptr_q  <= '0;
      flag_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (xfer) begin
        wen_q <= 1'b1;
        add_q <= add_d;
        dat_q <= sel_dat;
        lst_q <= sel_lst;
        gnt_q <= gnt;
        ptr_q <= ptr_d;
      end else if (bus.oram_rdy_i) begin
        wen_q <= 1'b0;
      end
      if (done_cond) begin
        flag_q <= '0;
        ptr_q  <= '0;
      end else begin
        flag_q <= flag_d;
      end
      done_q <= done_cond;
    end
  end

  assign bus.pe_out_rdy_o = xfer ? (PE_NUM'(1) << gnt) : '0;
  assign bus.oram_wen_o   = wen_q;
  assign bus.oram_add_o   = add_q;
  assign bus.oram_dat_o   = dat_q;
  assign bus.done_o       = done_q;
  assign bus.is_idle_o    = ~wen_q & ~(|req);
endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// Directed self-checking bench for eeg_pea_out_arb: inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_eeg_pea_out_arb;
  localparam int PE_NUM = 16;
  localparam int DW     = 8;
  localparam int AW     = 8;
  localparam int OAW    = 10;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  eeg_pea_out_arb_if #(.PE_NUM(PE_NUM), .DATA_OUT_DW(DW), .OMUX_ADD_AW(AW), .ORAM_ADD_AW(OAW)) bus ();

  eeg_pea_out_arb #(.PE_NUM(PE_NUM), .DATA_OUT_DW(DW), .OMUX_ADD_AW(AW), .ORAM_ADD_AW(OAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pe(input int i, input logic v, input logic l, input logic [7:0] a,
                        input logic [7:0] d);
    bus.pe_out_vld_i[i]          = v;
    bus.pe_out_lst_i[i]          = l;
    bus.pe_out_add_i[i*AW +: AW] = a;
    bus.pe_out_dat_i[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pe_out_vld_i = '0;
    bus.pe_out_lst_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] gnt_union;
    logic [15:0] r;
    int          beats[8];
    int          done_cnt;
    int          first_done;

    rst               = 1'b1;
    bus.cfg_out_bas_i = '0;
    bus.cfg_pe_msk_i  = '1;
    bus.pe_out_vld_i  = '1;
    bus.pe_out_lst_i  = '0;
    bus.pe_out_dat_i  = '0;
    bus.pe_out_add_i  = '0;
    bus.oram_rdy_i    = 1'b1;

    // Reset held with every PE requesting.
    @(negedge clk);
    chk("rst_rdy", bus.pe_out_rdy_o, 32'h0);
    chk("rst_wen", bus.oram_wen_o, 32'h0);
    chk("rst_done", bus.done_o, 32'h0);
    chk("rst_idle", bus.is_idle_o, 32'h0);
    chk("rst_add", bus.oram_add_o, 32'h0);
    next_cyc();
    bus.pe_out_vld_i = '0;
    rst = 1'b0;

    // Single PE beat and global address.
    bus.cfg_pe_msk_i  = 16'h0001;
    bus.cfg_out_bas_i = 10'h010;
    set_pe(0, 1'b1, 1'b0, 8'd3, 8'h5A);
    @(negedge clk);
    chk("single_rdy", bus.pe_out_rdy_o, 32'h0001);
    next_cyc();
    set_pe(0, 1'b0, 1'b0, 8'd0, 8'h00);
    @(negedge clk);
    chk("single_wen", bus.oram_wen_o, 32'h1);
    chk("single_add", bus.oram_add_o, 32'h040);
    chk("single_dat", bus.oram_dat_o, 32'h5A);
    next_cyc();
    @(negedge clk);
    chk("single_wen_drop", bus.oram_wen_o, 32'h0);
    chk("single_idle", bus.is_idle_o, 32'h1);

    // Fairness: all 16 PEs valid, one grant per cycle in index order.
    do_reset();
    bus.cfg_pe_msk_i  = '1;
    bus.cfg_out_bas_i = '0;
    for (int i = 0; i < PE_NUM; i++) set_pe(i, 1'b1, 1'b0, 8'(i), 8'(i * 3 + 1));
    gnt_union = '0;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt%0d", k), bus.pe_out_rdy_o, 32'(1) << (k % 16));
      if (k < 16) gnt_union = gnt_union | bus.pe_out_rdy_o;
      if (k >= 1) begin
        chk($sformatf("rr_wen%0d", k), bus.oram_wen_o, 32'h1);
        chk($sformatf("rr_add%0d", k), bus.oram_add_o, ((k - 1) % 16) * 17);
        chk($sformatf("rr_dat%0d", k), bus.oram_dat_o, ((k - 1) % 16) * 3 + 1);
      end
      next_cyc();
    end
    chk("rr_union", gnt_union, 32'hFFFF);
    bus.pe_out_vld_i = '0;

    // Backpressure: ORAM stalls 5 cycles with PE2 and PE7 pending.
    do_reset();
    bus.oram_rdy_i = 1'b0;
    set_pe(2, 1'b1, 1'b0, 8'd1, 8'h22);
    set_pe(7, 1'b1, 1'b0, 8'd2, 8'h77);
    @(negedge clk);
    chk("bp_first_gnt", bus.pe_out_rdy_o, 32'h0004);
    next_cyc();
    set_pe(2, 1'b0, 1'b0, 8'd0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_rdy%0d", k), bus.pe_out_rdy_o, 32'h0);
      chk($sformatf("bp_wen%0d", k), bus.oram_wen_o, 32'h1);
      chk($sformatf("bp_add%0d", k), bus.oram_add_o, 32'h012);
      chk($sformatf("bp_dat%0d", k), bus.oram_dat_o, 32'h22);
      next_cyc();
    end
    bus.oram_rdy_i = 1'b1;
    @(negedge clk);
    chk("bp_rel_gnt", bus.pe_out_rdy_o, 32'h0080);
    chk("bp_rel_add", bus.oram_add_o, 32'h012);
    next_cyc();
    set_pe(7, 1'b0, 1'b0, 8'd0, 8'h00);
    @(negedge clk);
    chk("bp_w2_wen", bus.oram_wen_o, 32'h1);
    chk("bp_w2_add", bus.oram_add_o, 32'h027);
    chk("bp_w2_dat", bus.oram_dat_o, 32'h77);
    next_cyc();
    @(negedge clk);
    chk("bp_drained", bus.oram_wen_o, 32'h0);

    // Layer completion: PEs 0-7 send 4 beats each, the 4th marked last.
    do_reset();
    bus.cfg_pe_msk_i = 16'h00FF;
    for (int p = 0; p < 8; p++) begin
      beats[p] = 0;
      set_pe(p, 1'b1, 1'b0, 8'd0, 8'(p << 4));
    end
    done_cnt   = 0;
    first_done = -1;
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      r = bus.pe_out_rdy_o;
      if (c < 32) chk($sformatf("dn_gnt%0d", c), r, 32'(1) << (c % 8));
      if (c >= 1 && c <= 32) begin
        chk($sformatf("dn_add%0d", c), bus.oram_add_o, ((c - 1) / 8) * 16 + (c - 1) % 8);
        chk($sformatf("dn_dat%0d", c), bus.oram_dat_o, (((c - 1) % 8) << 4) | ((c - 1) / 8));
      end
      if (bus.done_o) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
      end
      next_cyc();
      for (int p = 0; p < 8; p++) begin
        if (r[p]) begin
          beats[p]++;
          if (beats[p] == 4) set_pe(p, 1'b0, 1'b0, 8'd0, 8'h00);
          else set_pe(p, 1'b1, beats[p] == 3, 8'(beats[p]), 8'((p << 4) | beats[p]));
        end
      end
    end
    chk("dn_pulses", done_cnt, 32'd1);
    chk("dn_cycle", first_done, 32'd33);

    // Next layer restarts at PE0 with cleared flags.
    bus.cfg_pe_msk_i = 16'h02FF;
    set_pe(0, 1'b1, 1'b1, 8'd0, 8'hA0);
    set_pe(9, 1'b1, 1'b1, 8'd0, 8'hB9);
    @(negedge clk);
    chk("nl_first_gnt", bus.pe_out_rdy_o, 32'h0001);
    next_cyc();
    set_pe(0, 1'b0, 1'b0, 8'd0, 8'h00);
    @(negedge clk);
    chk("nl_second_gnt", bus.pe_out_rdy_o, 32'h0200);
    next_cyc();
    set_pe(9, 1'b0, 1'b0, 8'd0, 8'h00);
    done_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.done_o) done_cnt++;
      next_cyc();
    end
    chk("nl_no_done", done_cnt, 32'd0);

    // Empty mask: nothing granted, no done.
    bus.cfg_pe_msk_i = '0;
    bus.pe_out_vld_i = '1;
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("msk0_rdy%0d", k), bus.pe_out_rdy_o, 32'h0);
      if (bus.done_o) done_cnt++;
      next_cyc();
    end
    chk("msk0_idle", bus.is_idle_o, 32'h1);
    chk("msk0_no_done", done_cnt, 32'd0);
    bus.pe_out_vld_i = '0;

    // Address wrap at the ORAM size.
    bus.cfg_pe_msk_i  = '1;
    bus.cfg_out_bas_i = 10'h3F0;
    set_pe(5, 1'b1, 1'b0, 8'd255, 8'hC3);
    @(negedge clk);
    chk("wrap_gnt", bus.pe_out_rdy_o, 32'h0020);
    next_cyc();
    set_pe(5, 1'b0, 1'b0, 8'd0, 8'h00);
    @(negedge clk);
    chk("wrap_add", bus.oram_add_o, 32'h3E5);
    chk("wrap_dat", bus.oram_dat_o, 32'hC3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
